// File: rtl/regwrite_arb_pkg.sv
// Shared widths, the XZR register index, the write-request record and the output-stage states
// for the register-file write arbiter.
package regwrite_arb_pkg;

    localparam int DEF_N   = 64;
    localparam int DEF_A   = 5;
    localparam int DEF_R   = 2;
    localparam int XZR_IDX = (1 << DEF_A) - 1;

    typedef struct packed {
        logic [DEF_A-1:0] addr;
        logic [DEF_N-1:0] data;
    } wr_req_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_t;

endpackage

// File: rtl/rr_pick.sv
// Purpose: round-robin pick of the first set request at or after ptr, returning one-hot grant and index.
// Latency: purely combinational.
// Backpressure: none; the caller masks req when it cannot accept.
module rr_pick
    import regwrite_arb_pkg::*;
#(
    parameter int R  = DEF_R,
    parameter int PW = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [R-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          found
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < R; k++) begin
            j = int'(ptr) + k;
            if (j >= R) j = j - R;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/regwrite_arbiter.sv
// Purpose: round-robin share of the register-file write port into a one-entry output stage (XZR drop: REGWRITE_ARB_XZR_FILTER_EN).
// Latency: a write accepted at cycle t drives wr_* at t+1; one write per cycle when not stalled.
// Backpressure: wr_stall on a full stage blocks every grant; a retiring stage accepts a new write in the same cycle.
module regwrite_arbiter
    import regwrite_arb_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int A = DEF_A,
    parameter int R = DEF_R
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [R-1:0]        req_valid,
    output logic [R-1:0]        req_ready,
    input  logic [R-1:0][A-1:0] req_addr,
    input  logic [R-1:0][N-1:0] req_data,
    input  logic                wr_stall,
    output logic                wr_en,
    output logic [A-1:0]        wr_addr,
    output logic [N-1:0]        wr_data
);

    localparam int PW = $clog2(R);

    stage_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d, win_idx;
    logic [R-1:0]   grant;
    logic           found, can_accept, is_xzr, load;

    assign wr_en      = (state_q == FULL);
    assign can_accept = !wr_en || !wr_stall;

    // Reset also silences the handshake so no requester believes it was accepted.
    rr_pick #(.R(R), .PW(PW)) u_pick (
        .req   (req_valid & {R{can_accept && !reset}}),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .found (found)
    );

    assign req_ready = grant;

`ifdef REGWRITE_ARB_XZR_FILTER_EN
    assign is_xzr = (req_addr[win_idx] == {A{1'b1}});
`else
    assign is_xzr = 1'b0;
`endif

    // A filtered XZR grant still completes the handshake but never fills the stage.
    assign load = found && !is_xzr;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (load) begin
            state_d = FULL;
        end else if (!wr_stall) begin
            state_d = EMPTY;
        end
        if (found) begin
            ptr_d = (int'(win_idx) == R - 1) ? '0 : win_idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr <= '0;
            wr_data <= '0;
        end else if (load) begin
            wr_addr <= req_addr[win_idx];
            wr_data <= req_data[win_idx];
        end
    end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Directed and randomized checks of regwrite_arbiter against a cycle-level behavioural model.
module tb_regwrite_arbiter;
    import regwrite_arb_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [1:0]          req_valid = 2'b11;
    logic [1:0]          req_ready;
    logic [1:0][4:0]     req_addr = '0;
    logic [1:0][63:0]    req_data = '0;
    logic                wr_stall = 1'b0;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [63:0]         wr_data;

    int passed = 0;
    int total  = 0;

    // Model state: pending register write and the index of the highest-priority requester.
    bit      m_en   = 1'b0;
    wr_req_t m_out  = '0;
    int      m_prio = 0;

    regwrite_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wr_stall  (wr_stall),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    function automatic int model_winner();
        if (reset) return -1;
        if (m_en && wr_stall) return -1;
        for (int k = 0; k < DEF_R; k++) begin
            int i = (m_prio + k) % DEF_R;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [1:0] model_ready();
        int w = model_winner();
        logic [1:0] r = 2'b00;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic model_clock();
        int  w = model_winner();
        bit  drop = 1'b0;
        if (reset) begin
            m_en = 1'b0; m_out = '0; m_prio = 0;
            return;
        end
`ifdef REGWRITE_ARB_XZR_FILTER_EN
        if (w >= 0 && int'(req_addr[w]) == XZR_IDX) drop = 1'b1;
`endif
        if (w >= 0 && !drop) begin
            m_en = 1'b1;
            m_out.addr = req_addr[w];
            m_out.data = req_data[w];
        end else if (!wr_stall) begin
            m_en = 1'b0;
        end
        if (w >= 0) m_prio = (w + 1) % DEF_R;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 2'b11; wr_stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            total++;
            if (req_ready !== 2'b00 || wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 64'd0) begin
                $display("FAIL reset_state c=%0d got ready=%b en=%b addr=%0d data=%h want 0", c, req_ready, wr_en, wr_addr, wr_data);
            end else passed++;
            @(posedge clk); model_clock();
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (req_ready !== 2'b01) $display("FAIL reset_first_grant got %b want 01", req_ready);
        else passed++;
        @(posedge clk); model_clock();
    endtask

    task automatic test_alternate();
        logic [1:0] prev = 2'b00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = (c < 4) ? 2'b11 : 2'b00; wr_stall = 1'b0;
            req_addr[0] = 5'd3; req_data[0] = 64'hAAAA;
            req_addr[1] = 5'd7; req_data[1] = 64'h5555;
            #1;
            total++;
            if (req_ready !== model_ready()) $display("FAIL alt_ready c=%0d got %b want %b", c, req_ready, model_ready());
            else passed++;
            if (c > 0 && c < 4) begin
                total++;
                if (req_ready !== ~prev) $display("FAIL alt_toggle c=%0d got %b want %b", c, req_ready, ~prev);
                else passed++;
            end
            prev = req_ready;
            total++;
            if (wr_en !== m_en || (m_en && (wr_addr !== m_out.addr || wr_data !== m_out.data)))
                $display("FAIL alt_out c=%0d got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", c, wr_en, wr_addr, wr_data, m_en, m_out.addr, m_out.data);
            else passed++;
            @(posedge clk); model_clock();
        end
    endtask

    task automatic test_single();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = (c < 3) ? 2'b10 : 2'b00; wr_stall = 1'b0;
            req_addr[1] = 5'd9; req_data[1] = 64'h1234;
            #1;
            if (c < 3) begin
                total++;
                if (req_ready !== 2'b10) $display("FAIL single_ready c=%0d got %b want 10", c, req_ready);
                else passed++;
            end
            if (c > 0) begin
                total++;
                if (wr_en !== 1'b1 || wr_addr !== 5'd9 || wr_data !== 64'h1234)
                    $display("FAIL single_out c=%0d got en=%b addr=%0d data=%h want 1/9/1234", c, wr_en, wr_addr, wr_data);
                else passed++;
            end
            @(posedge clk); model_clock();
        end
    endtask

    task automatic test_stall();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = (c < 4) ? 2'b01 : 2'b00;
            req_addr[0] = (c == 0) ? 5'd4 : 5'd6;
            req_data[0] = (c == 0) ? 64'h44 : 64'h66;
            wr_stall = (c == 1 || c == 2);
            #1;
            total++;
            if (req_ready !== model_ready()) $display("FAIL stall_ready c=%0d got %b want %b", c, req_ready, model_ready());
            else passed++;
            if (c == 1 || c == 2) begin
                total++;
                if (req_ready !== 2'b00 || wr_en !== 1'b1 || wr_addr !== 5'd4)
                    $display("FAIL stall_hold c=%0d got ready=%b en=%b addr=%0d want 00/1/4", c, req_ready, wr_en, wr_addr);
                else passed++;
            end
            if (c == 4) begin
                total++;
                if (wr_en !== 1'b1 || wr_addr !== 5'd6 || wr_data !== 64'h66)
                    $display("FAIL stall_release got en=%b addr=%0d data=%h want 1/6/66", wr_en, wr_addr, wr_data);
                else passed++;
            end
            @(posedge clk); model_clock();
        end
    endtask

    task automatic test_reset_full();
        @(negedge clk);
        req_valid = 2'b10; wr_stall = 1'b0; req_addr[1] = 5'd12; req_data[1] = 64'hBEEF;
        @(posedge clk); model_clock();
        @(negedge clk);
        reset = 1'b1; req_valid = 2'b11; wr_stall = 1'b1;
        @(posedge clk); model_clock();
        @(negedge clk);
        reset = 1'b0; wr_stall = 1'b0;
        #1;
        total++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 64'd0)
            $display("FAIL reset_full_out got en=%b addr=%0d data=%h want 0/0/0", wr_en, wr_addr, wr_data);
        else passed++;
        total++;
        if (req_ready !== 2'b01) $display("FAIL reset_full_ptr got %b want 01", req_ready);
        else passed++;
        @(posedge clk); model_clock();
    endtask

    task automatic test_xzr();
        @(negedge clk);
        req_valid = 2'b00; wr_stall = 1'b0;
        @(posedge clk); model_clock();
        @(negedge clk);
        req_valid = 2'b01; req_addr[0] = 5'd31; req_data[0] = 64'hFFFF;
        #1;
        total++;
        if (req_ready[0] !== 1'b1) $display("FAIL xzr_ready got %b want 1", req_ready[0]);
        else passed++;
        @(posedge clk); model_clock();
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        total++;
`ifdef REGWRITE_ARB_XZR_FILTER_EN
        if (wr_en !== 1'b0) $display("FAIL xzr_filtered got en=%b want 0", wr_en);
        else passed++;
`else
        if (wr_en !== 1'b1 || wr_addr !== 5'd31 || wr_data !== 64'hFFFF)
            $display("FAIL xzr_pass got en=%b addr=%0d data=%h want 1/31/ffff", wr_en, wr_addr, wr_data);
        else passed++;
`endif
        @(posedge clk); model_clock();
    endtask

    task automatic test_random();
        logic [1:0] pend = 2'b00;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 39) == 0);
            wr_stall = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 2; i++) begin
                // A waiting requester keeps its valid, address and data stable.
                if (!pend[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_addr[i]  = 5'($urandom);
                    req_data[i]  = {32'($urandom), 32'($urandom)};
                end
            end
            #1;
            total++;
            if (req_ready !== model_ready()) $display("FAIL rand_ready c=%0d got %b want %b", c, req_ready, model_ready());
            else passed++;
            total++;
            if (wr_en !== m_en || (m_en && (wr_addr !== m_out.addr || wr_data !== m_out.data)))
                $display("FAIL rand_out c=%0d got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", c, wr_en, wr_addr, wr_data, m_en, m_out.addr, m_out.data);
            else passed++;
            pend = reset ? 2'b00 : (req_valid & ~req_ready);
            @(posedge clk); model_clock();
        end
        @(negedge clk);
        reset = 1'b0; req_valid = 2'b00; wr_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_stall();
        test_reset_full();
        test_xzr();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/regwrite_arbiter.md
Name: regwrite_arbiter

Overview:
- Shares the single write port of the 64-bit register file between R requesters, e.g. ALU writeback and load return.
- Arbitrates with a round-robin grant and a valid/ready handshake per requester.
- Registers the winning write into a one-entry output stage, so the register file sees at most one write per cycle.
- Sits between the writeback sources and the register file in the processor datapath.

Parameters:
- N, 64, data width of a register write.
- A, 5, register address width.
- R, 2, number of requesters (R >= 2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- req_valid  in  R  requester i presents a write.
- req_ready  out  R  requester i's write is accepted this cycle.
- req_addr  in  R x A  destination register per requester.
- req_data  in  R x N  write data per requester.
- wr_stall  in  1  register file cannot take a write this cycle.
- wr_en  out  1  output write valid.
- wr_addr  out  A  output write address.
- wr_data  out  N  output write data.

Behaviour:
- Reset (reset=1 at posedge):
  - wr_en=0, wr_addr=0, wr_data=0.
  - Round-robin pointer ptr=0, meaning requester 0 has highest priority next.
  - Reset overrides all other inputs in the same cycle; any in-flight output write is discarded.
- Output stage states: EMPTY (wr_en=0) and FULL (wr_en=1).
- can_accept = !wr_en || !wr_stall.
- Grant (combinational):
  - If can_accept, the winner is the first i with req_valid[i]=1, searching from ptr upward modulo R.
  - req_ready is one-hot for the winner, or all zero if there is no winner or can_accept=0.
  - req_ready never depends on req_data or req_addr.
- Transfer on requester i: req_valid[i] & req_ready[i] at posedge.
  - Loads {wr_addr, wr_data} from requester i; wr_en=1 next cycle.
  - Sets ptr = (i+1) mod R.
- No transfer:
  - FULL with wr_stall=1: output holds addr/data/en unchanged.
  - FULL with wr_stall=0 and no valid request: wr_en goes to 0; addr/data are retained but don't-care.
  - ptr is unchanged.
- Latency: accepted at cycle t, visible on wr_* at t+1.
- Throughput: one write per cycle with wr_stall=0.
- A requester that is valid but not ready must hold addr and data stable. The arbiter does not check this.
- Wrap-around: ptr increments modulo R; with R not a power of two, the increment from R-1 returns to 0.
- Simultaneous events:
  - wr_stall=1 while FULL blocks all grants.
  - wr_stall=0 while FULL allows the output write to retire and a new grant to be taken in the same cycle.
- Fairness: a continuously valid requester is granted within R cycles of wr_stall=0.

Optional Feature:
- Macro: REGWRITE_ARB_XZR_FILTER_EN.
- Defined:
  - A request with addr == 2^A-1 (XZR) is acknowledged (req_ready=1 when it wins) but does not load the output stage.
  - wr_en is unchanged by that grant; ptr still advances.
- Not defined: XZR writes pass through like any other address.

Decomposition:
- Shared package regwrite_arb_pkg holds:
  - Defaults for N, A, R.
  - XZR_IDX localparam.
  - typedef wr_req_t {logic [A-1:0] addr; logic [N-1:0] data;}.
- One sub-module: rr_pick. It is combinational, takes R-bit request and ptr, and returns a one-hot grant plus the index.
- The output stage uses the existing flopr pattern with a load enable inside regwrite_arbiter.

Test Plan:
- Reset held 3 cycles with req_valid=2'b11 -> wr_en=0, req_ready=0, wr_addr=0, wr_data=0 throughout; after release, requester 0 is granted first.
- req0 (addr 3, data 0xAAAA) and req1 (addr 7, data 0x5555) both valid for 4 cycles, wr_stall=0 -> grants alternate 0,1,0,1; wr_* show (3,AAAA),(7,5555),... each one cycle later.
- Only req1 valid (addr 9, data 0x1234) for 3 cycles -> req_ready=2'b10 every cycle; wr_en=1 from cycle 2 on with addr 9.
- Output FULL (addr 4), wr_stall=1 for 2 cycles with req0 valid -> req_ready=0, wr_addr stays 4; on stall release, req0 is granted in the same cycle and its write appears next cycle.
- reset asserted while FULL and requesters valid -> next cycle wr_en=0, ptr=0.
- With REGWRITE_ARB_XZR_FILTER_EN: req0 addr 31, data 0xFFFF -> req_ready[0]=1 and wr_en stays 0. Without the macro -> wr_en=1, wr_addr=31.
